cand_sweep_sched: RTL and testbench
===================================

CAND_SWEEP_SCHED -- requirements
Module: cand_sweep_sched

Interface
- REQ-001: Parameter J, default 14, number of symbol positions per candidate vector.
- REQ-002: Parameter A, default 2, alphabet size; AWIDTH = clog2(A)+1, JW = clog2(J)+1.
- REQ-003: Parameter TIMEOUT, default 4096, maximum cycles from gen_start to gen_row_tlast.
- REQ-004: clk  in  1  clock; all logic is rising-edge.
- REQ-005: rst_n  in  1  reset, synchronous, active-low.
- REQ-006: job_x  in  J*AWIDTH  initial symbol vector of a sweep job.
- REQ-007: job_first_idx / job_last_idx  in  JW each  inclusive J_index range to sweep.
- REQ-008: job_valid  in  1 / job_ready  out  1  job handshake; transfer when both are high.
- REQ-009: abort  in  1  request to terminate the current sweep.
- REQ-010: sink_ready  in  1  downstream can absorb one full candidate burst.
- REQ-011: gen_x_initial  out  J*AWIDTH, gen_x_initial_tvalid  out  1, gen_start  out  1, gen_J_index  out  JW  generator drive.
- REQ-012: gen_row_tvalid, gen_row_tlast  in  1 each  generator output stream monitor.
- REQ-013: busy  out  1; sweep_done  out  1 (pulse); sweep_err  out  1 (pulse); err_code  out  2; idx_cur  out  JW; row_count  out  16.

Function
- REQ-014: The FSM SHALL have states IDLE, LOAD, ARM, RUN, GAP, DRAIN, DONE.
- REQ-015: job_ready SHALL be 1 only in IDLE; busy SHALL be 1 in every state except IDLE.
- REQ-016: On a job handshake with first_idx <= last_idx and last_idx < J, the block SHALL capture job_x and the range, set idx_cur=first_idx, clear row_count, and enter LOAD.
- REQ-017: On a job handshake with first_idx > last_idx or last_idx >= J, the block SHALL stay in IDLE and pulse sweep_err one cycle with err_code=1, issuing no gen_start.
- REQ-018: LOAD SHALL last exactly one cycle, driving gen_x_initial=captured vector with gen_x_initial_tvalid=1, then enter ARM.
- REQ-019: In ARM, gen_start SHALL be pulsed for one cycle with gen_J_index=idx_cur in the first cycle sink_ready=1, then enter RUN; ARM SHALL wait indefinitely while sink_ready=0.
- REQ-020: gen_x_initial SHALL hold the captured vector and gen_J_index SHALL hold idx_cur from LOAD until return to IDLE.
- REQ-021: In RUN, each cycle with gen_row_tvalid=1 SHALL increment row_count, saturating at 65535.
- REQ-022: On gen_row_tvalid=1 and gen_row_tlast=1 in RUN: if idx_cur==last_idx, enter DONE; else idx_cur SHALL increment and the FSM enter GAP.
- REQ-023: GAP SHALL last exactly 2 cycles (generator recovery) then enter ARM; gen_start SHALL never be issued within 2 cycles after an accepted tlast.
- REQ-024: A RUN timeout counter SHALL clear on gen_start; reaching TIMEOUT cycles without tlast SHALL pulse sweep_err with err_code=2 and return to IDLE.
- REQ-025: abort in LOAD, ARM or GAP SHALL go to IDLE next cycle with sweep_err, err_code=3; abort in RUN SHALL enter DRAIN.
- REQ-026: DRAIN SHALL wait for gen_row_tlast (counting beats, subject to timeout), then pulse sweep_err with err_code=3 and enter IDLE.
- REQ-027: DONE SHALL last one cycle, pulse sweep_done, then enter IDLE; sweep_done and sweep_err SHALL never be high together.
- REQ-028: gen_row_tvalid outside RUN/DRAIN SHALL be ignored and not counted.
- REQ-029: err_code SHALL hold its last value until the next error; row_count and idx_cur SHALL hold after the sweep ends until the next accepted job.

Reset
- REQ-030: While rst_n=0 at a clock edge: state=IDLE, all gen_* outputs 0, sweep_done=0, sweep_err=0, err_code=0, idx_cur=0, row_count=0, timeout counter=0; job_ready=1 from the first cycle after reset release.
- REQ-031: Reset asserted mid-sweep SHALL abandon the sweep without a sweep_done or sweep_err pulse.

Verification
- REQ-032: Job first=0,last=2, sink_ready=1, stub generator 5 beats per burst -> 3 gen_start pulses with J_index 0,1,2, >=2 idle cycles after each tlast, row_count=15, one sweep_done.
- REQ-033: Job first=5,last=3 -> sweep_err pulse, err_code=1, no gen_start, job_ready stays 1.
- REQ-034: sink_ready held 0 for 20 cycles in ARM -> no gen_start until the cycle after sink_ready rises.
- REQ-035: Stub generator never asserts tlast, TIMEOUT=64 -> sweep_err with err_code=2 exactly 64 cycles after gen_start, state IDLE.
- REQ-036: abort in RUN of burst 2 of 4 -> no further gen_start, sweep_err err_code=3 only after that burst's tlast.
- REQ-037: rst_n low for one cycle during RUN -> all outputs at reset values next cycle, no done/err pulse.

Source files
------------

// File: rtl/cand_sweep_sched.sv
// cand_sweep_sched: steps a candidate generator across an inclusive J_index range,
// one burst per index, with recovery gaps, a per-burst timeout and abort handling.
module cand_sweep_sched #(
    parameter int unsigned J       = 14,
    parameter int unsigned A       = 2,
    parameter int unsigned TIMEOUT = 4096,
    localparam int unsigned AWIDTH = $clog2(A) + 1,
    localparam int unsigned JW     = $clog2(J) + 1,
    localparam int unsigned XW     = J * AWIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [XW-1:0] job_x,
    input  logic [JW-1:0] job_first_idx,
    input  logic [JW-1:0] job_last_idx,
    input  logic          job_valid,
    output logic          job_ready,
    input  logic          abort,
    input  logic          sink_ready,
    output logic [XW-1:0] gen_x_initial,
    output logic          gen_x_initial_tvalid,
    output logic          gen_start,
    output logic [JW-1:0] gen_J_index,
    input  logic          gen_row_tvalid,
    input  logic          gen_row_tlast,
    output logic          busy,
    output logic          sweep_done,
    output logic          sweep_err,
    output logic [1:0]    err_code,
    output logic [JW-1:0] idx_cur,
    output logic [15:0]   row_count
);
    localparam int unsigned TW          = $clog2(TIMEOUT + 1);
    localparam logic [1:0]  ERR_RANGE   = 2'd1;
    localparam logic [1:0]  ERR_TIMEOUT = 2'd2;
    localparam logic [1:0]  ERR_ABORT   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_RUN,
        S_GAP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [JW-1:0]   last_q, last_d;
    logic [JW-1:0]   idx_q, idx_d;
    logic [JW-1:0]   gen_idx_q, gen_idx_d;
    logic [15:0]     rows_q, rows_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            gap_q, gap_d;
    logic            start_q, start_d;
    logic            xvalid_q, xvalid_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [1:0]      code_q, code_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;

    logic            row_last;
    logic            timed_out;
    logic            count_beat;

    assign row_last   = gen_row_tvalid && gen_row_tlast;
    assign timed_out  = (timer_q == TW'(TIMEOUT - 1));
    assign count_beat = gen_row_tvalid && (state_q == S_RUN || state_q == S_DRAIN);

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        last_d    = last_q;
        idx_d     = idx_q;
        gen_idx_d = gen_idx_q;
        rows_d    = rows_q;
        timer_d   = timer_q;
        gap_d     = gap_q;
        start_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        code_d    = code_q;

        if (count_beat && rows_q != 16'hFFFF) begin
            rows_d = rows_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    if (job_first_idx <= job_last_idx && job_last_idx < JW'(J)) begin
                        x_d       = job_x;
                        last_d    = job_last_idx;
                        idx_d     = job_first_idx;
                        gen_idx_d = job_first_idx;
                        rows_d    = '0;
                        state_d   = S_LOAD;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_RANGE;
                    end
                end
            end
            S_LOAD: begin
                if (abort) begin
                    err_d   = 1'b1;
                    code_d  = ERR_ABORT;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (abort) begin
                    err_d   = 1'b1;
                    code_d  = ERR_ABORT;
                    state_d = S_IDLE;
                end else if (sink_ready) begin
                    start_d = 1'b1;
                    timer_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (row_last) begin
                    if (abort) begin
                        // burst already closed, so there is nothing left to drain
                        err_d   = 1'b1;
                        code_d  = ERR_ABORT;
                        state_d = S_IDLE;
                    end else if (idx_q == last_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d     = idx_q + JW'(1);
                        gen_idx_d = idx_q + JW'(1);
                        gap_d     = 1'b0;
                        state_d   = S_GAP;
                    end
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                    if (abort) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_GAP: begin
                if (abort) begin
                    err_d   = 1'b1;
                    code_d  = ERR_ABORT;
                    state_d = S_IDLE;
                end else if (gap_q) begin
                    state_d = S_ARM;
                end else begin
                    gap_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (row_last) begin
                    err_d   = 1'b1;
                    code_d  = ERR_ABORT;
                    state_d = S_IDLE;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // generator drive is parked at zero whenever no sweep is active
        if (state_d == S_IDLE) begin
            x_d       = '0;
            gen_idx_d = '0;
        end

        xvalid_d = (state_d == S_LOAD);
        busy_d   = (state_d != S_IDLE);
        ready_d  = (state_d == S_IDLE);
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            last_q    <= '0;
            idx_q     <= '0;
            gen_idx_q <= '0;
            rows_q    <= '0;
            timer_q   <= '0;
            gap_q     <= 1'b0;
            start_q   <= 1'b0;
            xvalid_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            gen_idx_q <= gen_idx_d;
            rows_q    <= rows_d;
            timer_q   <= timer_d;
            gap_q     <= gap_d;
            start_q   <= start_d;
            xvalid_q  <= xvalid_d;
            done_q    <= done_d;
            err_q     <= err_d;
            code_q    <= code_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    assign job_ready            = ready_q;
    assign busy                 = busy_q;
    assign gen_x_initial        = x_q;
    assign gen_x_initial_tvalid = xvalid_q;
    assign gen_start            = start_q;
    assign gen_J_index          = gen_idx_q;
    assign sweep_done           = done_q;
    assign sweep_err            = err_q;
    assign err_code             = code_q;
    assign idx_cur              = idx_q;
    assign row_count            = rows_q;

endmodule

// File: tb/tb_cand_sweep_sched.sv
// tb_cand_sweep_sched: table of sweep jobs run against a stub generator, with
// expected J_index and completion scoreboards, plus reset corner sequences.
module tb_cand_sweep_sched;
    localparam int unsigned J       = 14;
    localparam int unsigned A       = 2;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned AWIDTH  = $clog2(A) + 1;
    localparam int unsigned JW      = $clog2(J) + 1;
    localparam int unsigned XW      = J * AWIDTH;
    localparam int          NVEC    = 11;

    typedef struct {
        logic [JW-1:0] first;
        logic [JW-1:0] last;
        int            beats;
        bit            no_tlast;
        int            sink_delay;
        int            abort_start;
        int            abort_delay;
        bit            exp_done;
        logic [1:0]    exp_code;
        int            exp_starts;
        int            exp_rows;
        logic [JW-1:0] exp_idx;
    } vec_t;

    typedef struct {
        bit         done;
        logic [1:0] code;
    } comp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [XW-1:0] job_x = '0;
    logic [JW-1:0] job_first_idx = '0;
    logic [JW-1:0] job_last_idx = '0;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic          abort = 1'b0;
    logic          sink_ready = 1'b1;
    logic [XW-1:0] gen_x_initial;
    logic          gen_x_initial_tvalid;
    logic          gen_start;
    logic [JW-1:0] gen_J_index;
    logic          gen_row_tvalid = 1'b0;
    logic          gen_row_tlast = 1'b0;
    logic          busy;
    logic          sweep_done;
    logic          sweep_err;
    logic [1:0]    err_code;
    logic [JW-1:0] idx_cur;
    logic [15:0]   row_count;

    cand_sweep_sched #(.J(J), .A(A), .TIMEOUT(TIMEOUT)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .job_x                (job_x),
        .job_first_idx        (job_first_idx),
        .job_last_idx         (job_last_idx),
        .job_valid            (job_valid),
        .job_ready            (job_ready),
        .abort                (abort),
        .sink_ready           (sink_ready),
        .gen_x_initial        (gen_x_initial),
        .gen_x_initial_tvalid (gen_x_initial_tvalid),
        .gen_start            (gen_start),
        .gen_J_index          (gen_J_index),
        .gen_row_tvalid       (gen_row_tvalid),
        .gen_row_tlast        (gen_row_tlast),
        .busy                 (busy),
        .sweep_done           (sweep_done),
        .sweep_err            (sweep_err),
        .err_code             (err_code),
        .idx_cur              (idx_cur),
        .row_count            (row_count)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    bit            rst_req = 1'b1;
    bit            job_pend = 1'b0;
    int            cfg_beats = 0;
    bit            cfg_no_tlast = 1'b0;
    int            cfg_sink_delay = 0;
    int            cfg_abort_start = 0;
    int            cfg_abort_delay = 0;
    int            gen_left = 0;
    int            abort_cyc = -1;
    int            sink_rise_cyc = 0;
    int            start_cyc = 0;
    int            first_start_cyc = 0;
    int            tlast_cyc = 0;
    int            comp_cyc = 0;
    int            job_seq = 0;
    int            tlast_job = 0;
    int            job_starts = 0;
    int            n_comp = 0;
    logic [1:0]    exp_code = 2'd0;
    logic [XW-1:0] cur_x = '0;
    logic [JW-1:0] exp_idx_q[$];
    comp_t         comp_q[$];
    vec_t          vecs[NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Observe DUT outputs mid-cycle and score them against the expectation queues
    task automatic monitor();
        logic [JW-1:0] e_idx;
        comp_t         c;
        if (sweep_done === 1'b1 || sweep_err === 1'b1)
            check("done_err_exclusive", 64'(sweep_done & sweep_err), 64'd0);
        if (gen_x_initial_tvalid === 1'b1)
            check("x_initial_load", 64'(gen_x_initial), 64'(cur_x));
        if (gen_start === 1'b1) begin
            job_starts++;
            start_cyc = cyc;
            if (job_starts == 1) first_start_cyc = cyc;
            check("start_expected", 64'(exp_idx_q.size() != 0), 64'd1);
            if (exp_idx_q.size() != 0) begin
                e_idx = exp_idx_q.pop_front();
                check("start_J_index", 64'(gen_J_index), 64'(e_idx));
            end
            check("x_initial_hold", 64'(gen_x_initial), 64'(cur_x));
            if (tlast_job == job_seq)
                check("start_gap_after_tlast", 64'((cyc - tlast_cyc) >= 3), 64'd1);
            if (cfg_abort_start > 0 && job_starts == cfg_abort_start)
                abort_cyc = cyc + cfg_abort_delay;
        end
        if (gen_row_tvalid && gen_row_tlast) begin
            tlast_cyc = cyc;
            tlast_job = job_seq;
        end
        if (sweep_done === 1'b1 || sweep_err === 1'b1) begin
            n_comp++;
            comp_cyc = cyc;
            check("completion_expected", 64'(comp_q.size() != 0), 64'd1);
            if (comp_q.size() != 0) begin
                c = comp_q.pop_front();
                check("completion_kind", 64'(sweep_done), 64'(c.done));
                if (!c.done) check("err_code_pulse", 64'(err_code), 64'(c.code));
            end
        end
    endtask

    // One clock: drive inputs just after the rising edge, observe on the falling edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        rst_n     = !rst_req;
        job_valid = job_pend;
        if (job_pend) begin
            sink_rise_cyc = cyc + cfg_sink_delay;
            if (cfg_abort_start == 0 && cfg_abort_delay > 0) abort_cyc = cyc + cfg_abort_delay;
        end
        job_pend = 1'b0;
        if (gen_start === 1'b1 && gen_left == 0) gen_left = cfg_beats;
        if (gen_left > 0) begin
            gen_row_tvalid = 1'b1;
            gen_row_tlast  = !cfg_no_tlast && (gen_left == 1);
            gen_left--;
        end else begin
            gen_row_tvalid = 1'b0;
            gen_row_tlast  = 1'b0;
        end
        abort      = (cyc == abort_cyc);
        sink_ready = (cyc >= sink_rise_cyc);
        @(negedge clk);
        monitor();
    endtask

    task automatic setup_job(input vec_t v);
        job_seq++;
        job_starts      = 0;
        cfg_beats       = v.beats;
        cfg_no_tlast    = v.no_tlast;
        cfg_sink_delay  = v.sink_delay;
        cfg_abort_start = v.abort_start;
        cfg_abort_delay = v.abort_delay;
        abort_cyc       = -1;
        sink_rise_cyc   = 0;
        cur_x           = XW'($urandom());
        job_x           = cur_x;
        job_first_idx   = v.first;
        job_last_idx    = v.last;
        for (int i = 0; i < v.exp_starts; i++) exp_idx_q.push_back(JW'(int'(v.first) + i));
    endtask

    task automatic run_job(input vec_t v);
        int    n0;
        comp_t c;
        setup_job(v);
        c.done = v.exp_done;
        c.code = v.exp_code;
        comp_q.push_back(c);
        if (!v.exp_done) exp_code = v.exp_code;
        check("job_ready_idle", 64'(job_ready), 64'd1);
        n0 = n_comp;
        job_pend = 1'b1;
        for (int i = 0; i < 400 && n_comp == n0; i++) tick();
        check("job_completed", 64'(n_comp != n0), 64'd1);
        if (v.no_tlast)
            check("timeout_latency", 64'(comp_cyc - start_cyc), 64'(TIMEOUT));
        if (v.sink_delay >= 2 && v.exp_starts > 0)
            check("sink_to_start", 64'(first_start_cyc - sink_rise_cyc), 64'd1);
        if (v.abort_start > 0)
            check("abort_after_tlast", 64'(comp_cyc > tlast_cyc), 64'd1);
        repeat (3) tick();
        check("row_count", 64'(row_count), 64'(v.exp_rows));
        check("idx_cur", 64'(idx_cur), 64'(v.exp_idx));
        check("start_count", 64'(job_starts), 64'(v.exp_starts));
        check("err_code_sticky", 64'(err_code), 64'(exp_code));
        check("busy_after", 64'(busy), 64'd0);
        check("job_ready_after", 64'(job_ready), 64'd1);
        check("gen_x_initial_idle", 64'(gen_x_initial), 64'd0);
        exp_idx_q.delete();
        comp_q.delete();
    endtask

    initial begin
        vec_t rv;
        int   n0;
        // first, last, beats, no_tlast, sink_delay, abort_start, abort_delay,
        // exp_done, exp_code, exp_starts, exp_rows, exp_idx
        vecs[0]  = '{5'd0,  5'd2,  5,  1'b0, 0,  0, 0,  1'b1, 2'd0, 3,  15, 5'd2};
        vecs[1]  = '{5'd5,  5'd3,  5,  1'b0, 0,  0, 0,  1'b0, 2'd1, 0,  15, 5'd2};
        vecs[2]  = '{5'd2,  5'd14, 5,  1'b0, 0,  0, 0,  1'b0, 2'd1, 0,  15, 5'd2};
        vecs[3]  = '{5'd13, 5'd13, 3,  1'b0, 0,  0, 0,  1'b1, 2'd0, 1,  3,  5'd13};
        vecs[4]  = '{5'd4,  5'd4,  2,  1'b0, 20, 0, 0,  1'b1, 2'd0, 1,  2,  5'd4};
        vecs[5]  = '{5'd0,  5'd3,  5,  1'b0, 0,  2, 2,  1'b0, 2'd3, 2,  10, 5'd1};
        vecs[6]  = '{5'd6,  5'd8,  4,  1'b0, 0,  1, 4,  1'b0, 2'd3, 1,  4,  5'd7};
        vecs[7]  = '{5'd3,  5'd5,  5,  1'b0, 0,  0, 1,  1'b0, 2'd3, 0,  0,  5'd3};
        vecs[8]  = '{5'd2,  5'd2,  5,  1'b0, 30, 0, 10, 1'b0, 2'd3, 0,  0,  5'd2};
        vecs[9]  = '{5'd7,  5'd7,  10, 1'b1, 0,  0, 0,  1'b0, 2'd2, 1,  10, 5'd7};
        vecs[10] = '{5'd0,  5'd13, 1,  1'b0, 0,  0, 0,  1'b1, 2'd0, 14, 14, 5'd13};

        repeat (3) tick();
        rst_req = 1'b0;
        tick();
        check("rst_job_ready", 64'(job_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_gen_start", 64'(gen_start), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        check("rst_row_count", 64'(row_count), 64'd0);
        check("rst_idx_cur", 64'(idx_cur), 64'd0);

        for (int k = 0; k < NVEC; k++) run_job(vecs[k]);

        // Reset pulse during the first burst of a three-burst sweep
        rv = '{5'd0, 5'd2, 5, 1'b0, 0, 0, 0, 1'b1, 2'd0, 3, 15, 5'd2};
        setup_job(rv);
        job_pend = 1'b1;
        for (int i = 0; i < 50 && job_starts == 0; i++) tick();
        check("reset_seq_started", 64'(job_starts), 64'd1);
        repeat (2) tick();
        check("reset_seq_in_run", 64'(busy), 64'd1);
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        exp_idx_q.delete();
        exp_code = 2'd0;
        n0 = n_comp;
        tick();
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_job_ready", 64'(job_ready), 64'd1);
        check("midrst_gen_start", 64'(gen_start), 64'd0);
        check("midrst_x_tvalid", 64'(gen_x_initial_tvalid), 64'd0);
        check("midrst_x_initial", 64'(gen_x_initial), 64'd0);
        check("midrst_J_index", 64'(gen_J_index), 64'd0);
        check("midrst_done", 64'(sweep_done), 64'd0);
        check("midrst_err", 64'(sweep_err), 64'd0);
        check("midrst_err_code", 64'(err_code), 64'(exp_code));
        check("midrst_idx_cur", 64'(idx_cur), 64'd0);
        check("midrst_row_count", 64'(row_count), 64'd0);
        repeat (10) tick();
        check("midrst_no_pulse", 64'(n_comp - n0), 64'd0);
        check("midrst_beats_ignored", 64'(row_count), 64'd0);
        check("midrst_no_start", 64'(job_starts), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
